attack_fsm: RTL and testbench

- Attack sub-FSM feeding the player top-level state arbiter.
- Detects attack presses and selects the attack kind from direction inputs and grounded status.
- Sequences startup, active and recovery phases, counted in animation frames.
- Drives attack_active (the arbiter's ATTACK priority input), hitbox_active and an attack animation code.

---
 rtl/player_pkg.sv | 58 +++++
 rtl/btn_edge.sv | 18 +
 rtl/attack_fsm.sv | 133 +++++++++++++
 tb/tb_attack_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared player encodings: attack kinds, animation phases and state enums used by the
// top-level arbiter and its sub-FSMs.
package player_pkg;

    typedef enum logic [2:0] {
        ATK_NONE  = 3'd0,
        ATK_JAB   = 3'd1,
        ATK_FTILT = 3'd2,
        ATK_UTILT = 3'd3,
        ATK_DTILT = 3'd4,
        ATK_NAIR  = 3'd5
    } atk_kind_e;

    localparam logic [1:0] PHASE_IDLE     = 2'd0;
    localparam logic [1:0] PHASE_STARTUP  = 2'd1;
    localparam logic [1:0] PHASE_ACTIVE   = 2'd2;
    localparam logic [1:0] PHASE_RECOVERY = 2'd3;

    // Top-level player states arbitrated above the sub-FSMs.
    typedef enum logic [2:0] {
        PLAYER_IDLE,
        PLAYER_WALK,
        PLAYER_JUMP,
        PLAYER_ATTACK,
        PLAYER_SHIELD,
        PLAYER_HITSTUN
    } player_state_e;

    typedef enum logic [2:0] {
        ATK_ST_IDLE,
        ATK_ST_STARTUP,
        ATK_ST_ACTIVE,
        ATK_ST_RECOVERY,
        ATK_ST_LAND_LAG
    } atk_state_e;

    // Attack kind chosen from stick direction; opposing left+right cancel out.
    function automatic atk_kind_e select_kind(input logic grounded, input logic up,
                                              input logic down, input logic left,
                                              input logic right);
        if (!grounded)          return ATK_NAIR;
        else if (up)            return ATK_UTILT;
        else if (down)          return ATK_DTILT;
        else if (left ^ right)  return ATK_FTILT;
        else                    return ATK_JAB;
    endfunction

    function automatic logic [1:0] phase_of(input atk_state_e st);
        case (st)
            ATK_ST_STARTUP:  return PHASE_STARTUP;
            ATK_ST_ACTIVE:   return PHASE_ACTIVE;
            ATK_ST_RECOVERY,
            ATK_ST_LAND_LAG: return PHASE_RECOVERY;
            default:         return PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for an already-synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= btn;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/attack_fsm.sv
// Attack sub-FSM: press buffering, kind selection and startup/active/recovery sequencing
// in animation frames, with landing lag for aerials and hit-stun cancel.
module attack_fsm
    import player_pkg::*;
#(
    parameter int unsigned STARTUP_FRAMES  = 3,
    parameter int unsigned ACTIVE_FRAMES   = 4,
    parameter int unsigned RECOVERY_FRAMES = 8,
    parameter int unsigned LAND_LAG_FRAMES = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_atk,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       grounded,
    input  logic       hit_stun_active,
    output logic       attack_active,
    output logic       hitbox_active,
    output logic [2:0] atk_kind,
    output logic [4:0] atk_anim,
    output logic       facing_left
);

    localparam logic [CNT_W-1:0] LOAD_STARTUP  = CNT_W'(STARTUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOAD_ACTIVE   = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOAD_RECOVERY = CNT_W'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOAD_LAND_LAG = CNT_W'(LAND_LAG_FRAMES - 1);

    logic             press_c;
    atk_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pending, pending_nxt;
    atk_kind_e        kind, kind_nxt;
    logic             facing_nxt;
    logic             landing_c;

    btn_edge u_atk_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_atk),
        .press (press_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ATK_ST_IDLE;
            cnt           <= '0;
            pending       <= 1'b0;
            kind          <= ATK_NONE;
            facing_left   <= 1'b0;
            attack_active <= 1'b0;
            hitbox_active <= 1'b0;
            atk_anim      <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pending       <= pending_nxt;
            kind          <= kind_nxt;
            facing_left   <= facing_nxt;
            attack_active <= (state_nxt != ATK_ST_IDLE);
            hitbox_active <= (state_nxt == ATK_ST_ACTIVE);
            atk_anim      <= {phase_of(state_nxt), 3'(kind_nxt)};
        end
    end

    assign atk_kind = 3'(kind);

    // Landing only cancels an aerial that has not already dropped into landing lag.
    assign landing_c = (kind == ATK_NAIR) && grounded &&
                       (state == ATK_ST_STARTUP || state == ATK_ST_ACTIVE ||
                        state == ATK_ST_RECOVERY);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        kind_nxt    = kind;
        facing_nxt  = facing_left;

        // Presses are buffered only where another attack can follow.
        if (press_c && (state == ATK_ST_IDLE || state == ATK_ST_RECOVERY ||
                        state == ATK_ST_LAND_LAG))
            pending_nxt = 1'b1;

        if (hit_stun_active) begin
            state_nxt   = ATK_ST_IDLE;
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
            kind_nxt    = ATK_NONE;
        end else if (landing_c) begin
            state_nxt = ATK_ST_LAND_LAG;
            cnt_nxt   = LOAD_LAND_LAG;
        end else begin
            case (state)
                ATK_ST_IDLE: begin
                    if (frame_tick && (pending || press_c)) begin
                        kind_nxt    = select_kind(grounded, btn_up, btn_down, btn_left, btn_right);
                        if (kind_nxt == ATK_FTILT) facing_nxt = btn_left;
                        pending_nxt = 1'b0;
                        state_nxt   = ATK_ST_STARTUP;
                        cnt_nxt     = LOAD_STARTUP;
                    end
                end
                ATK_ST_STARTUP, ATK_ST_ACTIVE, ATK_ST_RECOVERY, ATK_ST_LAND_LAG: begin
                    if (frame_tick) begin
                        if (cnt != '0) begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end else if (state == ATK_ST_STARTUP) begin
                            state_nxt = ATK_ST_ACTIVE;
                            cnt_nxt   = LOAD_ACTIVE;
                        end else if (state == ATK_ST_ACTIVE) begin
                            state_nxt = ATK_ST_RECOVERY;
                            cnt_nxt   = LOAD_RECOVERY;
                        end else begin
                            state_nxt = ATK_ST_IDLE;
                            kind_nxt  = ATK_NONE;
                        end
                    end
                end
                default: begin
                    state_nxt = ATK_ST_IDLE;
                    kind_nxt  = ATK_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attack_fsm.sv
// Self-checking bench for attack_fsm: directed scenarios then random stimulus, all
// compared every clk against a frame-count reference model.
module tb_attack_fsm;

    localparam int S = 3;
    localparam int A = 4;
    localparam int R = 8;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, btn_atk, btn_up, btn_down, btn_left, btn_right;
    logic       grounded, hit_stun_active;
    logic       attack_active, hitbox_active, facing_left;
    logic [2:0] atk_kind;
    logic [4:0] atk_anim;

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 0;
    bit rand_ticks = 0;

    // Reference model: an attack is "elapsed frames since acceptance" plus an optional lag timer.
    bit m_busy, m_lag, m_pending, m_prev, m_facing;
    int m_elapsed, m_lag_left, m_kind;

    attack_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .btn_atk         (btn_atk),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .grounded        (grounded),
        .hit_stun_active (hit_stun_active),
        .attack_active   (attack_active),
        .hitbox_active   (hitbox_active),
        .atk_kind        (atk_kind),
        .atk_anim        (atk_anim),
        .facing_left     (facing_left)
    );

    always #5 clk = ~clk;

    function automatic int m_phase();
        if (!m_busy)               return 0;
        if (m_lag)                 return 3;
        if (m_elapsed < S)         return 1;
        if (m_elapsed < S + A)     return 2;
        return 3;
    endfunction

    task automatic m_update();
        bit press;
        press = btn_atk && !m_prev;
        if (!rst_n) begin
            m_busy = 0; m_lag = 0; m_pending = 0; m_prev = 0; m_facing = 0;
            m_elapsed = 0; m_lag_left = 0; m_kind = 0;
            return;
        end
        m_prev = btn_atk;
        if (hit_stun_active) begin
            m_busy = 0; m_lag = 0; m_pending = 0; m_kind = 0; m_elapsed = 0;
        end else if (!m_busy) begin
            if (frame_tick && (m_pending || press)) begin
                if (!grounded)                 m_kind = 5;
                else if (btn_up)               m_kind = 3;
                else if (btn_down)             m_kind = 4;
                else if (btn_left != btn_right) m_kind = 2;
                else                           m_kind = 1;
                if (m_kind == 2) m_facing = btn_left;
                m_busy = 1; m_lag = 0; m_elapsed = 0; m_pending = 0;
            end else if (press) begin
                m_pending = 1;
            end
        end else begin
            if (press && (m_lag || m_elapsed >= S + A)) m_pending = 1;
            if (!m_lag && m_kind == 5 && grounded) begin
                m_lag = 1; m_lag_left = L;
            end else if (frame_tick) begin
                if (m_lag) begin
                    m_lag_left--;
                    if (m_lag_left == 0) begin m_busy = 0; m_lag = 0; m_kind = 0; end
                end else begin
                    m_elapsed++;
                    if (m_elapsed == S + A + R) begin m_busy = 0; m_kind = 0; end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        int ph;
        frame_tick = rand_ticks ? ($urandom_range(0, 3) == 0) : (tick_div == 9);
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        @(posedge clk);
        m_update();
        #1;
        ph = m_phase();
        chk("attack_active", 8'(attack_active), 8'(m_busy));
        chk("hitbox_active", 8'(hitbox_active), 8'(ph == 2));
        chk("atk_kind",      8'(atk_kind),      8'(m_kind));
        chk("atk_anim",      8'(atk_anim),      8'(ph * 8 + m_kind));
        chk("facing_left",   8'(facing_left),   8'(m_facing));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_atk();
        btn_atk = 1'b1; step(); btn_atk = 1'b0;
    endtask

    task automatic run_until_phase(input int p, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (m_phase() == p) return;
            step();
        end
        n_cmp++;
        n_err++;
        $error("FAIL wait_phase observed=timeout expected=phase %0d", p);
    endtask

    initial begin
        rst_n = 0; frame_tick = 0; btn_atk = 0; btn_up = 0; btn_down = 0;
        btn_left = 0; btn_right = 0; grounded = 1; hit_stun_active = 0;
        steps(2);
        rst_n = 1;
        steps(3);

        // Grounded jab through all three phases.
        press_atk();
        steps(200);

        // Ftilt left turns the player, then utilt keeps the facing.
        btn_left = 1; press_atk(); steps(10); btn_left = 0;
        steps(200);
        btn_up = 1; btn_left = 1; press_atk(); steps(20);
        btn_up = 0; btn_left = 0;
        steps(180);

        // Aerial cancelled by landing during the active window.
        grounded = 0; press_atk();
        run_until_phase(2, 100);
        steps(12);
        grounded = 1;
        steps(80);

        // Press in ACTIVE is dropped; press in RECOVERY is buffered.
        press_atk();
        run_until_phase(2, 100);
        steps(5); press_atk();
        run_until_phase(3, 100);
        steps(15); press_atk();
        steps(300);

        // Hit stun in ACTIVE, with the button pressed and held through the stun.
        press_atk();
        run_until_phase(2, 100);
        steps(8);
        hit_stun_active = 1; btn_atk = 1;
        steps(3);
        hit_stun_active = 0;
        steps(40);
        btn_atk = 0;
        steps(20);

        // Reset mid-startup clears facing too.
        btn_left = 1; press_atk();
        run_until_phase(1, 100);
        steps(5);
        rst_n = 0; step(); rst_n = 1;
        btn_left = 0;
        steps(30);

        // Random stimulus with irregular frame ticks.
        rand_ticks = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_atk = ~btn_atk;
            if ($urandom_range(0, 7) == 0) {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
            if ($urandom_range(0, 30) == 0) grounded = ~grounded;
            hit_stun_active = ($urandom_range(0, 150) == 0);
            rst_n = ($urandom_range(0, 800) != 0);
            step();
        end
        rst_n = 1; hit_stun_active = 0;
        steps(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
